// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave for a multicycle CPU: accepts one access at a time,
// inserts WAIT_STATES wait cycles, then reports completion with a registered ready/error pulse.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_d;

    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              strb_q;
    logic                    wr_q;
    logic                    err_q;

    logic [31:0]             mem [DEPTH];

    logic                    req_c;
    logic                    req_err_c;
    logic [ADDR_WIDTH-1:0]   req_idx_c;
    logic [ADDR_WIDTH-1:0]   rd_idx_c;
    logic                    accept_c;
    logic                    rd_ok_c;
    logic                    load_rd_c;
    logic                    commit_c;
    logic                    ready_d;
    logic                    busy_d;
    logic                    error_d;

    // Request decode: misaligned, out-of-range or conflicting read+write are rejected
    assign req_c     = memory_read | memory_write;
    assign req_idx_c = address[ADDR_WIDTH+1:2];
    assign req_err_c = (address[1:0] != 2'b00)
                     || ((address >> (ADDR_WIDTH + 2)) != 32'd0)
                     || (memory_read && memory_write);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        case (state)
            IDLE: begin
                if (req_c) begin
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic; ready/error fire on the edge leaving RESP, so a reset there suppresses them
    always_comb begin
        accept_c  = (state == IDLE) && req_c;
        rd_idx_c  = (state == IDLE) ? req_idx_c : idx_q;
        rd_ok_c   = (state == IDLE) ? (memory_read && !req_err_c) : (!wr_q && !err_q);
        load_rd_c = (next_state == RESP) && (state != RESP) && rd_ok_c;
        commit_c  = (state == RESP) && wr_q && !err_q;
        ready_d   = (state == RESP);
        error_d   = (state == RESP) && err_q;
        busy_d    = (next_state != IDLE);
    end

    // Registered outputs and the latched access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            read_data <= 32'h0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready <= ready_d;
            busy  <= busy_d;
            error <= error_d;
            if (accept_c) begin
                idx_q   <= req_idx_c;
                wdata_q <= write_data;
                strb_q  <= write_strobe;
                wr_q    <= memory_write;
                err_q   <= req_err_c;
            end
            if (load_rd_c) begin
                read_data <= mem[rd_idx_c];
            end
        end
    end

    // Storage is never cleared; byte lanes commit on the edge leaving RESP
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
